// File: rtl/gir_pkg.sv
// Shared constants, index-width helper and busy-vector type for the
// multi-port general integer register file.
package gir_pkg;

    localparam int          XLEN       = 64;
    localparam int          NREG       = 32;
    localparam logic [63:0] START_ADDR = 64'h8000_0000;

    // Index width for a register file of n entries; never narrower than 1 bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One pending-write bit per register of the default-size file.
    typedef logic [NREG-1:0] busy_vec_t;

endpackage

// File: rtl/gir_en_reg.sv
// Generic enable register cell with synchronous active-high reset.
module gir_en_reg #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load d when enabled, otherwise hold; reset wins over the enable.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (rst)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/gir_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on write-back or flush, and read out per read port.
module gir_scoreboard
    import gir_pkg::*;
#(
    parameter int NREG = gir_pkg::NREG,
    parameter int NWR  = 2,
    parameter int NRD  = 2,
    localparam int IW  = idx_w(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [IW-1:0]     iss_index,
    input  logic              flush,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*IW-1:0] wt_index,
    input  logic [NRD*IW-1:0] rd_index,
    input  logic [NRD-1:0]    rd_hit,
    output logic [NRD-1:0]    rbusy
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic [NREG-1:0] wr_vec;

    // Decode all write ports into a one-hot-per-register write mask.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred.
        wr_vec = '0;
        for (int j = 0; j < NWR; j++)
            if (wen[j])
                wr_vec[wt_index[j*IW +: IW]] = 1'b1;
    end

    // Priority: issue over flush over write-back clear over hold; x0 never busy.
    always_comb begin
        if (flush)
            busy_nxt = '0;
        else
            busy_nxt = busy & ~wr_vec;
        if (iss_valid)
            busy_nxt[iss_index] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Busy state register.
    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    // A read is busy unless a forwarded write satisfies it this cycle.
    always_comb begin
        rbusy = '0;
        for (int i = 0; i < NRD; i++)
            rbusy[i] = busy[rd_index[i*IW +: IW]] & ~rd_hit[i];
    end

endmodule

// File: rtl/gir_mp.sv
// Multi-port general integer register file with optional write-to-read
// bypass, pending-write scoreboard and stallable PC register.
module gir_mp #(
    parameter int              XLEN       = gir_pkg::XLEN,
    parameter int              NREG       = gir_pkg::NREG,
    parameter int              NRD        = 2,
    parameter int              NWR        = 2,
    parameter bit              BYPASS     = 1'b1,
    parameter logic [XLEN-1:0] START_ADDR = XLEN'(gir_pkg::START_ADDR),
    localparam int             IW         = gir_pkg::idx_w(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*IW-1:0]   rd_index,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*IW-1:0]   wt_index,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                iss_valid,
    input  logic [IW-1:0]       iss_index,
    input  logic                flush,
    input  logic                pc_wen,
    input  logic [XLEN-1:0]     dnpc,
    output logic [XLEN-1:0]     pc
);

    import gir_pkg::*;

    logic [XLEN-1:0] regs [NREG];
    logic [NRD-1:0]  rd_hit;
    logic [NRD-1:0]  byp_hit;

    // Register array write; later ports overwrite earlier ones on collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the array is reset because software relies on zeroed registers after reset.
            for (int k = 0; k < NREG; k++)
                regs[k] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (wen[j] && wt_index[j*IW +: IW] != '0)
                    regs[wt_index[j*IW +: IW]] <= wdata[j*XLEN +: XLEN];
        end
    end

    // Combinational read with optional forwarding; highest write port wins.
    always_comb begin
        rdata  = '0;
        rd_hit = '0;
        for (int i = 0; i < NRD; i++) begin
            rdata[i*XLEN +: XLEN] = regs[rd_index[i*IW +: IW]];
            for (int j = 0; j < NWR; j++)
                if (wen[j] && wt_index[j*IW +: IW] == rd_index[i*IW +: IW]) begin
                    rd_hit[i] = 1'b1;
                    if (BYPASS)
                        rdata[i*XLEN +: XLEN] = wdata[j*XLEN +: XLEN];
                end
            if (rd_index[i*IW +: IW] == '0) begin
                rdata[i*XLEN +: XLEN] = '0;
                rd_hit[i]             = 1'b0;
            end
        end
    end

    // Without forwarding a same-cycle write does not unblock the reader.
    assign byp_hit = BYPASS ? rd_hit : '0;

    gir_scoreboard #(
        .NREG (NREG),
        .NWR  (NWR),
        .NRD  (NRD)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_index (iss_index),
        .flush     (flush),
        .wen       (wen),
        .wt_index  (wt_index),
        .rd_index  (rd_index),
        .rd_hit    (byp_hit),
        .rbusy     (rbusy)
    );

    gir_en_reg #(
        .W       (XLEN),
        .RST_VAL (START_ADDR)
    ) u_pc (
        .clk (clk),
        .rst (rst),
        .en  (pc_wen),
        .d   (dnpc),
        .q   (pc)
    );

endmodule

// File: tb/tb_gir_mp.sv
// Self-checking bench for gir_mp: one bypassing and one non-bypassing
// instance share stimulus; a vector table drives both, then a short PC sequence.
module tb_gir_mp;

    localparam int IW = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   rd_index;
    logic [1:0]   wen;
    logic [9:0]   wt_index;
    logic [127:0] wdata;
    logic         iss_valid;
    logic [4:0]   iss_index;
    logic         flush;
    logic         pc_wen;
    logic [63:0]  dnpc;

    logic [127:0] rdata_b, rdata_n;
    logic [1:0]   rbusy_b, rbusy_n;
    logic [63:0]  pc_b, pc_n;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    gir_mp #(.BYPASS(1'b1)) u_byp (
        .clk (clk), .rst (rst), .rd_index (rd_index), .rdata (rdata_b), .rbusy (rbusy_b),
        .wen (wen), .wt_index (wt_index), .wdata (wdata), .iss_valid (iss_valid),
        .iss_index (iss_index), .flush (flush), .pc_wen (pc_wen), .dnpc (dnpc), .pc (pc_b)
    );

    gir_mp #(.BYPASS(1'b0)) u_nob (
        .clk (clk), .rst (rst), .rd_index (rd_index), .rdata (rdata_n), .rbusy (rbusy_n),
        .wen (wen), .wt_index (wt_index), .wdata (wdata), .iss_valid (iss_valid),
        .iss_index (iss_index), .flush (flush), .pc_wen (pc_wen), .dnpc (dnpc), .pc (pc_n)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  wen;
        logic [4:0]  wt0;
        logic [63:0] wd0;
        logic [4:0]  wt1;
        logic [63:0] wd1;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic        iss_v;
        logic [4:0]  iss_i;
        logic        flush;
        logic        pc_wen;
        logic [63:0] dnpc;
        logic [63:0] eb0;   // bypass instance, read port 0
        logic [63:0] eb1;   // bypass instance, read port 1
        logic [63:0] en0;   // non-bypass instance, read port 0
        logic [1:0]  ebb;   // bypass instance rbusy
        logic [1:0]  ebn;   // non-bypass instance rbusy
        logic [63:0] epc;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic apply(input vec_t v);
        rst       = v.rst;
        wen       = v.wen;
        wt_index  = {v.wt1, v.wt0};
        wdata     = {v.wd1, v.wd0};
        rd_index  = {v.rd1, v.rd0};
        iss_valid = v.iss_v;
        iss_index = v.iss_i;
        flush     = v.flush;
        pc_wen    = v.pc_wen;
        dnpc      = v.dnpc;
    endtask

    initial begin
        //         rst wen   wt0   wd0         wt1   wd1       rd0    rd1    iv   ii     fl   pw   dnpc            eb0         eb1       en0         ebb    ebn    epc
        tbl[0]  = '{0, 2'b01, 5'd0, 64'hDEAD,   5'd0, 64'h0,    5'd0,  5'd0,  0, 5'd0,  0,   1,  64'h8000_0004, 64'h0,      64'h0,    64'h0,      2'b00, 2'b00, 64'h8000_0000};
        tbl[1]  = '{0, 2'b11, 5'd5, 64'h11,     5'd5, 64'h22,   5'd5,  5'd0,  0, 5'd0,  0,   1,  64'h8000_0008, 64'h22,     64'h0,    64'h0,      2'b00, 2'b00, 64'h8000_0004};
        tbl[2]  = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd5,  5'd0,  0, 5'd0,  0,   0,  64'hDEAD,      64'h22,     64'h0,    64'h22,     2'b00, 2'b00, 64'h8000_0008};
        tbl[3]  = '{0, 2'b01, 5'd3, 64'h7,      5'd0, 64'h0,    5'd3,  5'd5,  0, 5'd0,  0,   0,  64'h0,         64'h7,      64'h22,   64'h0,      2'b00, 2'b00, 64'h8000_0008};
        tbl[4]  = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd3,  5'd5,  0, 5'd0,  0,   0,  64'h0,         64'h7,      64'h22,   64'h7,      2'b00, 2'b00, 64'h8000_0008};
        tbl[5]  = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd8,  5'd3,  1, 5'd8,  0,   1,  64'h8000_0010, 64'h0,      64'h7,    64'h0,      2'b00, 2'b00, 64'h8000_0008};
        tbl[6]  = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd8,  5'd3,  0, 5'd0,  0,   0,  64'h0,         64'h0,      64'h7,    64'h0,      2'b01, 2'b01, 64'h8000_0010};
        tbl[7]  = '{0, 2'b10, 5'd0, 64'h0,      5'd8, 64'h88,   5'd8,  5'd8,  0, 5'd0,  0,   0,  64'h0,         64'h88,     64'h88,   64'h0,      2'b00, 2'b11, 64'h8000_0010};
        tbl[8]  = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd8,  5'd8,  0, 5'd0,  0,   0,  64'h0,         64'h88,     64'h88,   64'h88,     2'b00, 2'b00, 64'h8000_0010};
        tbl[9]  = '{0, 2'b01, 5'd8, 64'h99,     5'd0, 64'h0,    5'd8,  5'd0,  1, 5'd8,  0,   0,  64'h0,         64'h99,     64'h0,    64'h88,     2'b00, 2'b00, 64'h8000_0010};
        tbl[10] = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd8,  5'd0,  0, 5'd0,  0,   0,  64'h0,         64'h99,     64'h0,    64'h99,     2'b01, 2'b01, 64'h8000_0010};
        tbl[11] = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd8,  5'd1,  1, 5'd1,  0,   0,  64'h0,         64'h99,     64'h0,    64'h99,     2'b01, 2'b01, 64'h8000_0010};
        tbl[12] = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd1,  5'd2,  1, 5'd2,  0,   0,  64'h0,         64'h0,      64'h0,    64'h0,      2'b01, 2'b01, 64'h8000_0010};
        tbl[13] = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd2,  5'd31, 1, 5'd31, 0,   0,  64'h0,         64'h0,      64'h0,    64'h0,      2'b01, 2'b01, 64'h8000_0010};
        tbl[14] = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd1,  5'd31, 1, 5'd4,  1,   0,  64'h0,         64'h0,      64'h0,    64'h0,      2'b11, 2'b11, 64'h8000_0010};
        tbl[15] = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd4,  5'd1,  0, 5'd0,  0,   0,  64'h0,         64'h0,      64'h0,    64'h0,      2'b01, 2'b01, 64'h8000_0010};
        tbl[16] = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd2,  5'd8,  0, 5'd0,  0,   0,  64'h0,         64'h0,      64'h99,   64'h0,      2'b00, 2'b00, 64'h8000_0010};
        tbl[17] = '{0, 2'b01, 5'd9, 64'h9999,   5'd0, 64'h0,    5'd9,  5'd0,  0, 5'd0,  0,   1,  64'h20,        64'h9999,   64'h0,    64'h0,      2'b00, 2'b00, 64'h8000_0010};
        tbl[18] = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd9,  5'd0,  0, 5'd0,  0,   0,  64'h0,         64'h9999,   64'h0,    64'h9999,   2'b00, 2'b00, 64'h20};
        tbl[19] = '{1, 2'b01, 5'd9, 64'h1234,   5'd0, 64'h0,    5'd0,  5'd0,  1, 5'd9,  0,   1,  64'hABC,       64'h0,      64'h0,    64'h0,      2'b00, 2'b00, 64'h20};
        tbl[20] = '{0, 2'b00, 5'd0, 64'h0,      5'd0, 64'h0,    5'd9,  5'd8,  0, 5'd0,  0,   0,  64'h0,         64'h0,      64'h0,    64'h0,      2'b00, 2'b00, 64'h8000_0000};

        // Reset both instances for two cycles.
        rst = 1'b1; wen = '0; wt_index = '0; wdata = '0; rd_index = '0;
        iss_valid = 1'b0; iss_index = '0; flush = 1'b0; pc_wen = 1'b0; dnpc = '0;
        repeat (2) @(posedge clk);
        #1;

        // Table: drive just after the edge, sample mid-cycle, then advance.
        for (int i = 0; i < 21; i++) begin
            apply(tbl[i]);
            #4;
            check($sformatf("v%0d_byp_rdata0", i), rdata_b[63:0],   tbl[i].eb0);
            check($sformatf("v%0d_byp_rdata1", i), rdata_b[127:64], tbl[i].eb1);
            check($sformatf("v%0d_nob_rdata0", i), rdata_n[63:0],   tbl[i].en0);
            check($sformatf("v%0d_byp_rbusy", i),  64'(rbusy_b),    64'(tbl[i].ebb));
            check($sformatf("v%0d_nob_rbusy", i),  64'(rbusy_n),    64'(tbl[i].ebn));
            check($sformatf("v%0d_pc", i),         pc_b,            tbl[i].epc);
            @(posedge clk);
            #1;
        end

        // PC advances every enabled cycle, then holds when stalled.
        wen = '0; iss_valid = 1'b0; flush = 1'b0; rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pc_wen = 1'b1;
            dnpc   = 64'h1000 + 64'(4 * k);
            @(posedge clk);
            #1;
            check($sformatf("pc_seq%0d", k), pc_n, 64'h1000 + 64'(4 * k));
        end
        pc_wen = 1'b0;
        dnpc   = 64'hFFFF;
        @(posedge clk);
        #1;
        check("pc_seq_hold", pc_n, 64'h100C);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
